// File: rtl/vliw_fetch_unit_if.sv
// vliw_fetch_unit_if: bundle-load bus, control strobes and issue outputs
// shared between the fetch unit (slave) and whatever drives it (master).
interface vliw_fetch_unit_if #(
  parameter int AW = 4
);
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [47:0]   load_data;
  logic          start;
  logic          stall;
  logic [31:0]   instruction;
  logic [7:0]    operand1;
  logic [7:0]    operand2;
  logic          issue_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  modport master (
    output load_en, load_addr, load_data, start, stall,
    input  instruction, operand1, operand2, issue_valid, pc, busy, done
  );

  modport slave (
    input  load_en, load_addr, load_data, start, stall,
    output instruction, operand1, operand2, issue_valid, pc, busy, done
  );
endinterface

// File: rtl/vliw_fetch_unit.sv
// vliw_fetch_unit: walks a small bundle memory and issues one 48-bit bundle
// {instruction, operand1, operand2} per unstalled clock to the processor.
// Execution stops on a bundle whose slot-0 opcode equals HALT_OP, or at the
// end of memory.
// Optional feature macro: FETCH_LOOP_EN -- when defined, issuing the last
// entry wraps pc to 0 and keeps running; otherwise the last entry ends the run.
module vliw_fetch_unit #(
  parameter int         DEPTH   = 16,
  parameter int         AW      = 4,
  parameter logic [7:0] HALT_OP = 8'hFF
) (
  input logic              clk,
  input logic              rst,
  vliw_fetch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bundle store; not cleared by reset. Read asynchronously so that an entry
  // written on the start edge is already visible to the first issue.
  logic [47:0] mem [DEPTH];

  state_t        state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [31:0]   instr_reg, instr_next;
  logic [7:0]    opa_reg, opa_next;
  logic [7:0]    opb_reg, opb_next;
  logic          valid_reg, valid_next;

  logic [47:0]   rd_entry;
  logic          rd_is_halt;
  logic          mem_we;

  assign rd_entry   = mem[pc_reg];
  assign rd_is_halt = (rd_entry[47:40] == HALT_OP);
  // Loading is only allowed while the program is not executing.
  assign mem_we     = bus.load_en && (state_reg != S_RUN);

  // Bundle memory write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[bus.load_addr] <= bus.load_data;
    end
  end

  // State, pc and issue output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      instr_reg <= '0;
      opa_reg   <= '0;
      opb_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      opa_reg   <= opa_next;
      opb_reg   <= opb_next;
      valid_reg <= valid_next;
    end
  end

  // Next-state and issue decisions; stall outranks HALT detection.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    opa_next   = opa_reg;
    opb_next   = opb_reg;
    valid_next = 1'b0;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_next = S_RUN;
          pc_next    = '0;
        end
      end
      S_RUN: begin
        if (!bus.stall) begin
          if (rd_is_halt) begin
            // HALT is never issued; pc keeps pointing at it.
            state_next = S_DONE;
          end else begin
            instr_next = rd_entry[47:16];
            opa_next   = rd_entry[15:8];
            opb_next   = rd_entry[7:0];
            valid_next = 1'b1;
            pc_next    = pc_reg + AW'(1);
`ifndef FETCH_LOOP_EN
            // Last entry issued: finish here, pc has wrapped to 0.
            if (pc_reg == AW'(DEPTH - 1)) begin
              state_next = S_DONE;
            end
`endif
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        pc_next    = '0;
      end
    endcase
  end

  assign bus.instruction = instr_reg;
  assign bus.operand1    = opa_reg;
  assign bus.operand2    = opb_reg;
  assign bus.issue_valid = valid_reg;
  assign bus.pc          = pc_reg;
  assign bus.busy        = (state_reg == S_RUN);
  assign bus.done        = (state_reg == S_DONE);

endmodule

// File: tb/tb_vliw_fetch_unit.sv
// tb_vliw_fetch_unit: scoreboard bench for vliw_fetch_unit. Expected bundles
// are queued when a run is started and compared as issue_valid pulses appear.
module tb_vliw_fetch_unit;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam logic [47:0] HALT_B = {8'hFF, 40'h0};

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   issue_cnt = 0;
  bit   sb_en = 1'b0;
  logic [47:0] exp_q[$];
  logic [47:0] mon_got, mon_exp;

  vliw_fetch_unit_if #(.AW(AW)) bus ();

  vliw_fetch_unit #(.DEPTH(DEPTH), .AW(AW), .HALT_OP(8'hFF)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] mk(input int i);
    mk = {8'(i + 1), 8'hA5, 16'(i * 257), 8'(i * 7 + 1), 8'(255 - i)};
  endfunction

  // Scoreboard monitor: every issued bundle is compared with the queue head.
  always @(negedge clk) begin
    if (bus.issue_valid === 1'b1) begin
      issue_cnt++;
      if (sb_en) begin
        checks++;
        mon_got = {bus.instruction, bus.operand1, bus.operand2};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_issue: got %h, required no issue", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            errors++;
            $display("FAIL issue_bundle: got %h, required %h", mon_got, mon_exp);
          end else begin
            $display("issue pc_after=%0d bundle=%h", bus.pc, mon_got);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [47:0] d);
    bus.load_en   = 1'b1;
    bus.load_addr = a;
    bus.load_data = d;
    tick();
    bus.load_en   = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      #1;
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({bus.instruction, bus.operand1, bus.operand2} !== 48'h0) begin errors++; $display("FAIL reset_outputs: got %h, required 0", {bus.instruction, bus.operand1, bus.operand2}); end
    checks++; if ({bus.issue_valid, bus.busy, bus.done} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b, required 000", {bus.issue_valid, bus.busy, bus.done}); end
    checks++; if (bus.pc !== AW'(0)) begin errors++; $display("FAIL reset_pc: got %0d, required 0", bus.pc); end
    // Mid-run reset.
    for (int i = 0; i < DEPTH; i++) load(AW'(i), mk(i));
    sb_en = 1'b0;
    start_pulse();
    tick();
    tick();
    bus.stall = 1'b1;
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL run_busy: got %b, required 1", bus.busy); end
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    @(negedge clk);
    checks++; if ({bus.instruction, bus.operand1, bus.operand2} !== 48'h0) begin errors++; $display("FAIL midrun_reset_outputs: got %h, required 0", {bus.instruction, bus.operand1, bus.operand2}); end
    checks++; if ({bus.issue_valid, bus.busy, bus.done} !== 3'b000) begin errors++; $display("FAIL midrun_reset_flags: got %b, required 000", {bus.issue_valid, bus.busy, bus.done}); end
    checks++; if (bus.pc !== AW'(0)) begin errors++; $display("FAIL midrun_reset_pc: got %0d, required 0", bus.pc); end
    $display("test_reset complete");
    exp_q.delete();
    sb_en = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    load(AW'(0), {32'h0001_0000, 8'd5, 8'd7});
    load(AW'(1), HALT_B);
    exp_q.push_back({32'h0001_0000, 8'd5, 8'd7});
    issue_cnt = 0;
    start_pulse();
    @(negedge clk);
    checks++; if ({bus.busy, bus.issue_valid} !== 2'b10) begin errors++; $display("FAIL basic_latency: got busy,valid=%b, required 10", {bus.busy, bus.issue_valid}); end
    wait_done(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done: got timeout, required done=1"); end
    checks++; if (issue_cnt !== 1) begin errors++; $display("FAIL basic_issue_count: got %0d, required 1", issue_cnt); end
    checks++; if (bus.pc !== AW'(1)) begin errors++; $display("FAIL basic_pc: got %0d, required 1", bus.pc); end
    checks++; if ({bus.busy, bus.issue_valid} !== 2'b00) begin errors++; $display("FAIL basic_done_flags: got %b, required 00", {bus.busy, bus.issue_valid}); end
    checks++; if (bus.instruction !== 32'h0001_0000) begin errors++; $display("FAIL basic_hold: got %h, required 00010000", bus.instruction); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_queue: got %0d left, required 0", exp_q.size()); end
    $display("test_basic complete");
  endtask

  task automatic test_stall();
    bit ok;
    logic [47:0] b0;
    b0 = mk(0);
    for (int i = 0; i < 3; i++) load(AW'(i), mk(i));
    load(AW'(3), HALT_B);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(i));
    issue_cnt = 0;
    start_pulse();
    tick();
    bus.stall = 1'b1;
    @(negedge clk);
    checks++; if (bus.issue_valid !== 1'b1) begin errors++; $display("FAIL stall_first_issue: got %b, required 1", bus.issue_valid); end
    for (int s = 0; s < 2; s++) begin
      tick();
      @(negedge clk);
      checks++; if (bus.issue_valid !== 1'b0) begin errors++; $display("FAIL stall_valid: got %b, required 0", bus.issue_valid); end
      checks++; if (bus.instruction !== b0[47:16]) begin errors++; $display("FAIL stall_hold: got %h, required %h", bus.instruction, b0[47:16]); end
      checks++; if (bus.pc !== AW'(1)) begin errors++; $display("FAIL stall_pc: got %0d, required 1", bus.pc); end
    end
    bus.stall = 1'b0;
    wait_done(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_done: got timeout, required done=1"); end
    checks++; if (issue_cnt !== 3) begin errors++; $display("FAIL stall_issue_count: got %0d, required 3", issue_cnt); end
    checks++; if (bus.pc !== AW'(3)) begin errors++; $display("FAIL stall_end_pc: got %0d, required 3", bus.pc); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stall_queue: got %0d left, required 0", exp_q.size()); end
    $display("test_stall complete");
  endtask

  task automatic test_end_of_memory();
    bit ok;
    for (int i = 0; i < DEPTH; i++) load(AW'(i), mk(i));
    issue_cnt = 0;
`ifdef FETCH_LOOP_EN
    for (int i = 0; i < DEPTH + 4; i++) exp_q.push_back(mk(i % DEPTH));
    start_pulse();
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      #1;
      if (issue_cnt >= DEPTH + 4) break;
    end
    rst = 1'b1;
    checks++; if (issue_cnt !== DEPTH + 4) begin errors++; $display("FAIL loop_issue_count: got %0d, required %0d", issue_cnt, DEPTH + 4); end
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin errors++; $display("FAIL loop_still_running: got %b, required 10", {bus.busy, bus.done}); end
    tick();
    rst = 1'b0;
    load(AW'(3), HALT_B);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(i));
    issue_cnt = 0;
    start_pulse();
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL loop_halt_done: got timeout, required done=1"); end
    checks++; if (issue_cnt !== 3) begin errors++; $display("FAIL loop_halt_count: got %0d, required 3", issue_cnt); end
    checks++; if (bus.pc !== AW'(3)) begin errors++; $display("FAIL loop_halt_pc: got %0d, required 3", bus.pc); end
`else
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(mk(i));
    start_pulse();
    wait_done(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL eom_done: got timeout, required done=1"); end
    checks++; if (issue_cnt !== DEPTH) begin errors++; $display("FAIL eom_issue_count: got %0d, required %0d", issue_cnt, DEPTH); end
    checks++; if (bus.pc !== AW'(0)) begin errors++; $display("FAIL eom_pc: got %0d, required 0", bus.pc); end
`endif
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL eom_queue: got %0d left, required 0", exp_q.size()); end
    $display("test_end_of_memory complete");
  endtask

  task automatic test_load_gating();
    bit ok;
    logic [47:0] a, b;
    a = {32'h1234_5678, 8'h11, 8'h22};
    b = {32'h0BAD_F00D, 8'h33, 8'h44};
    load(AW'(0), a);
    load(AW'(1), b);
    load(AW'(2), HALT_B);
    exp_q.push_back(a);
    exp_q.push_back(b);
    issue_cnt = 0;
    start_pulse();
    load(AW'(0), {32'hDEAD_BEEF, 8'h99, 8'h88});
    wait_done(20, ok);
    checks++; if (!ok || issue_cnt !== 2) begin errors++; $display("FAIL gating_first_run: got done=%b count=%0d, required 1 and 2", ok, issue_cnt); end
    exp_q.push_back(a);
    exp_q.push_back(b);
    issue_cnt = 0;
    start_pulse();
    wait_done(20, ok);
    checks++; if (!ok || issue_cnt !== 2) begin errors++; $display("FAIL gating_restart: got done=%b count=%0d, required 1 and 2", ok, issue_cnt); end
    checks++; if (bus.pc !== AW'(2)) begin errors++; $display("FAIL gating_pc: got %0d, required 2", bus.pc); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL gating_queue: got %0d left, required 0", exp_q.size()); end
    $display("test_load_gating complete");
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [47:0] c;
    c = {32'h0042_0042, 8'h5A, 8'hC3};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    load(AW'(1), HALT_B);
    exp_q.push_back(c);
    issue_cnt = 0;
    bus.load_en   = 1'b1;
    bus.load_addr = AW'(0);
    bus.load_data = c;
    bus.start     = 1'b1;
    tick();
    bus.load_en   = 1'b0;
    bus.start     = 1'b0;
    wait_done(20, ok);
    checks++; if (!ok || issue_cnt !== 1) begin errors++; $display("FAIL load_start_same_cycle: got done=%b count=%0d, required 1 and 1", ok, issue_cnt); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_queue: got %0d left, required 0", exp_q.size()); end
    $display("test_back_to_back complete");
  endtask

  initial begin
    rst           = 1'b1;
    bus.load_en   = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_end_of_memory();
    test_load_gating();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required bench completion");
    $fatal(1, "watchdog expired");
  end
endmodule
